operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 162 ++++++++++++++++
 tb/tb_operand_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: eight 16-bit registers with one write port, and a
// four-state sequencer that reads the A and B operands into internal latches
// and presents them to the ALU until the consumer acknowledges.
// Optional B-operand shifter is built only when OPERAND_FETCH_SHIFTER_EN is
// defined; otherwise the shift input is ignored and B passes through unshifted.

module operand_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        ready,
   input  logic [2:0]  rn,
   input  logic [2:0]  rm,
   input  logic [1:0]  shift,
   input  logic        asel,
   input  logic        bsel,
   input  logic [15:0] sximm5,
   input  logic        w_en,
   input  logic [2:0]  w_num,
   input  logic [15:0] w_data,
   output logic [15:0] val_A,
   output logic [15:0] val_B,
   output logic        valid,
   input  logic        ack
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ_A = 2'd1,
      READ_B = 2'd2,
      VALID  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [2:0]  rn_q, rn_d;
   logic [2:0]  rm_q, rm_d;
   logic        asel_q, asel_d;
   logic        bsel_q, bsel_d;
   logic [15:0] sximm5_q, sximm5_d;
   logic [15:0] b_shifted;

`ifdef OPERAND_FETCH_SHIFTER_EN
   logic [1:0]  shift_q, shift_d;
`else
   logic        unused_shift;
   assign unused_shift = ^shift;
`endif

   // Next-state: register writes on any state, operand capture and latching
   always_comb begin
      state_d  = state_q;
      regs_d   = regs_q;
      a_d      = a_q;
      b_d      = b_q;
      rn_d     = rn_q;
      rm_d     = rm_q;
      asel_d   = asel_q;
      bsel_d   = bsel_q;
      sximm5_d = sximm5_q;
`ifdef OPERAND_FETCH_SHIFTER_EN
      shift_d  = shift_q;
`endif

      if (w_en) begin
         regs_d[w_num] = w_data;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               rn_d     = rn;
               rm_d     = rm;
               asel_d   = asel;
               bsel_d   = bsel;
               sximm5_d = sximm5;
`ifdef OPERAND_FETCH_SHIFTER_EN
               shift_d  = shift;
`endif
               state_d  = READ_A;
            end
         end
         READ_A: begin
            a_d     = (w_en && (w_num == rn_q)) ? w_data : regs_q[rn_q];
            state_d = READ_B;
         end
         READ_B: begin
            b_d     = (w_en && (w_num == rm_q)) ? w_data : regs_q[rm_q];
            state_d = VALID;
         end
         VALID: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset clearing everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= 16'h0000;
         end
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         rn_q     <= 3'd0;
         rm_q     <= 3'd0;
         asel_q   <= 1'b0;
         bsel_q   <= 1'b0;
         sximm5_q <= 16'h0000;
`ifdef OPERAND_FETCH_SHIFTER_EN
         shift_q  <= 2'b00;
`endif
      end else begin
         state_q  <= state_d;
         regs_q   <= regs_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rn_q     <= rn_d;
         rm_q     <= rm_d;
         asel_q   <= asel_d;
         bsel_q   <= bsel_d;
         sximm5_q <= sximm5_d;
`ifdef OPERAND_FETCH_SHIFTER_EN
         shift_q  <= shift_d;
`endif
      end
   end

`ifdef OPERAND_FETCH_SHIFTER_EN
   // B-operand shifter driven by the captured shift code
   always_comb begin
      b_shifted = b_q;
      case (shift_q)
         2'b01:   b_shifted = {b_q[14:0], 1'b0};
         2'b10:   b_shifted = {1'b0, b_q[15:1]};
         2'b11:   b_shifted = {b_q[15], b_q[15:1]};
         default: b_shifted = b_q;
      endcase
   end
`else
   // B operand passes through unshifted
   always_comb begin
      b_shifted = b_q;
   end
`endif

   // Output operand muxing and handshake flags from the current state
   always_comb begin
      ready = (state_q == IDLE);
      valid = (state_q == VALID);
      val_A = asel_q ? 16'h0000 : a_q;
      val_B = bsel_q ? sximm5_q : b_shifted;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: table of directed fetches plus
// hand-written sequences for bypass, reset abort and held start/ack.

module tb_operand_fetch;

   logic        clk;
   logic        reset;
   logic        start;
   logic        ready;
   logic [2:0]  rn;
   logic [2:0]  rm;
   logic [1:0]  shift;
   logic        asel;
   logic        bsel;
   logic [15:0] sximm5;
   logic        w_en;
   logic [2:0]  w_num;
   logic [15:0] w_data;
   logic [15:0] val_A;
   logic [15:0] val_B;
   logic        valid;
   logic        ack;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [2:0]  rn;
      logic [2:0]  rm;
      logic [1:0]  shift;
      logic        asel;
      logic        bsel;
      logic [15:0] sximm5;
      logic [15:0] expA;
      logic [15:0] expB;
   } vector_t;

   vector_t vectors [8];

   operand_fetch dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .ready  (ready),
      .rn     (rn),
      .rm     (rm),
      .shift  (shift),
      .asel   (asel),
      .bsel   (bsel),
      .sximm5 (sximm5),
      .w_en   (w_en),
      .w_num  (w_num),
      .w_data (w_data),
      .val_A  (val_A),
      .val_B  (val_B),
      .valid  (valid),
      .ack    (ack)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vector_t v);
      rn     = v.rn;
      rm     = v.rm;
      shift  = v.shift;
      asel   = v.asel;
      bsel   = v.bsel;
      sximm5 = v.sximm5;
   endtask

   task automatic writeReg(input logic [2:0] num, input logic [15:0] data);
      w_en   = 1'b1;
      w_num  = num;
      w_data = data;
      @(negedge clk);
      w_en   = 1'b0;
   endtask

   // Full fetch: start at this negedge, check latency, operands, then ack
   task automatic runFetch(input string name, input vector_t v);
      applyStimulus(v);
      checkOutput({name, " ready_idle"}, {15'd0, ready}, 16'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput({name, " valid_e1"}, {15'd0, valid}, 16'd0);
      @(negedge clk);
      checkOutput({name, " valid_e2"}, {15'd0, valid}, 16'd0);
      @(negedge clk);
      checkOutput({name, " valid_e3"}, {15'd0, valid}, 16'd1);
      checkOutput({name, " ready_busy"}, {15'd0, ready}, 16'd0);
      checkOutput({name, " val_A"}, val_A, v.expA);
      checkOutput({name, " val_B"}, val_B, v.expB);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput({name, " valid_after_ack"}, {15'd0, valid}, 16'd0);
      checkOutput({name, " ready_after_ack"}, {15'd0, ready}, 16'd1);
   endtask

   initial begin
      vector_t v;
      logic [15:0] expSar, expShr, expShl, expR4Shl, expR3Shr;

`ifdef OPERAND_FETCH_SHIFTER_EN
      expSar   = 16'hC001;
      expShr   = 16'h4001;
      expShl   = 16'h0004;
      expR4Shl = 16'h2468;
      expR3Shr = 16'h0000;
`else
      expSar   = 16'h8002;
      expShr   = 16'h8002;
      expShl   = 16'h8002;
      expR4Shl = 16'h1234;
      expR3Shr = 16'h0001;
`endif

      //                 rn    rm    sh     as    bs    sximm5     expA       expB
      vectors[0] = '{3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd7,     16'd3};
      vectors[1] = '{3'd0, 3'd2, 2'b11, 1'b0, 1'b0, 16'h0000, 16'd7,     expSar};
      vectors[2] = '{3'd0, 3'd2, 2'b10, 1'b0, 1'b0, 16'h0000, 16'd7,     expShr};
      vectors[3] = '{3'd0, 3'd2, 2'b01, 1'b0, 1'b0, 16'h0000, 16'd7,     expShl};
      vectors[4] = '{3'd0, 3'd1, 2'b00, 1'b1, 1'b1, 16'hFFF0, 16'h0000,  16'hFFF0};
      vectors[5] = '{3'd1, 3'd0, 2'b11, 1'b0, 1'b1, 16'h0005, 16'd3,     16'h0005};
      vectors[6] = '{3'd4, 3'd4, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h1234,  expR4Shl};
      vectors[7] = '{3'd2, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h8002,  expR3Shr};

      reset = 1'b1; start = 1'b0; ack = 1'b0;
      rn = 3'd0; rm = 3'd0; shift = 2'b00; asel = 1'b0; bsel = 1'b0;
      sximm5 = 16'h0000; w_en = 1'b0; w_num = 3'd0; w_data = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset ready", {15'd0, ready}, 16'd1);
      checkOutput("reset valid", {15'd0, valid}, 16'd0);
      checkOutput("reset val_A", val_A, 16'h0000);
      checkOutput("reset val_B", val_B, 16'h0000);
      reset = 1'b0;

      writeReg(3'd0, 16'd7);
      writeReg(3'd1, 16'd3);
      writeReg(3'd2, 16'h8002);
      writeReg(3'd3, 16'd1);
      writeReg(3'd4, 16'h1234);

      for (int i = 0; i < 8; i++) begin
         runFetch($sformatf("vec%0d", i), vectors[i]);
      end

      // Bypass in READ_A, then a write in VALID must not disturb operands
      v = '{3'd3, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd69, 16'd3};
      applyStimulus(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w_en = 1'b1; w_num = 3'd3; w_data = 16'd69;
      ack = 1'b1;
      @(negedge clk);
      w_en = 1'b0;
      ack = 1'b0;
      @(negedge clk);
      checkOutput("bypass valid", {15'd0, valid}, 16'd1);
      checkOutput("bypass val_A", val_A, 16'd69);
      w_en = 1'b1; w_num = 3'd3; w_data = 16'd500;
      @(negedge clk);
      w_en = 1'b1; w_num = 3'd1; w_data = 16'd600;
      @(negedge clk);
      w_en = 1'b0;
      checkOutput("hold val_A", val_A, 16'd69);
      checkOutput("hold val_B", val_B, 16'd3);
      checkOutput("hold valid", {15'd0, valid}, 16'd1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      // Registers now hold the VALID-time writes
      runFetch("postwrite", '{3'd3, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd500, 16'd600});

      // Reset during READ_B aborts the fetch; reset beats w_en
      applyStimulus('{3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      w_en = 1'b1; w_num = 3'd5; w_data = 16'hFFFF;
      @(negedge clk);
      reset = 1'b0;
      w_en = 1'b0;
      checkOutput("abort ready", {15'd0, ready}, 16'd1);
      checkOutput("abort valid", {15'd0, valid}, 16'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("abort no_valid%0d", k), {15'd0, valid}, 16'd0);
      end
      for (int k = 0; k < 8; k++) begin
         runFetch($sformatf("zero_r%0d", k),
                  '{k[2:0], k[2:0], 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000});
      end

      // Start held through a fetch and into VALID with ack
      writeReg(3'd0, 16'd7);
      writeReg(3'd1, 16'd3);
      applyStimulus('{3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0});
      start = 1'b1;
      @(negedge clk);
      applyStimulus('{3'd1, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0});
      @(negedge clk);
      @(negedge clk);
      checkOutput("held valid", {15'd0, valid}, 16'd1);
      checkOutput("held val_A", val_A, 16'd7);
      checkOutput("held val_B", val_B, 16'd3);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput("held ack ready", {15'd0, ready}, 16'd1);
      checkOutput("held ack valid", {15'd0, valid}, 16'd0);
      @(negedge clk);
      start = 1'b0;
      checkOutput("held restart ready", {15'd0, ready}, 16'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("second valid", {15'd0, valid}, 16'd1);
      checkOutput("second val_A", val_A, 16'd3);
      checkOutput("second val_B", val_B, 16'd7);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput("second done", {15'd0, ready}, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
